// File: rtl/cpu_clock_ctrl.sv
// cpu_clock_ctrl: derives the slow CPU clock cpu_clk from clk, with run / step / burst / hold modes,
// a synchronised and debounced step button, a CPU-cycle counter and an optional PC breakpoint.
// Ports: clk, rst (async active-low); mode, step_btn, burst_len, pc, break_pc, break_valid in;
//        cpu_clk, cpu_clk_rise, busy, cycle_cnt, break_hit out. All outputs are registered.
// Breakpoint logic is compiled in only when CLKCTRL_BREAK_EN is defined; otherwise break_hit is 0.
module cpu_clock_ctrl #(
   parameter int DIV_HALF   = 5000000,
   parameter int DEB_CYCLES = 1000000,
   parameter int BURST_W    = 8,
   parameter int CNT_W      = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [1:0]         mode,
   input  logic               step_btn,
   input  logic [BURST_W-1:0] burst_len,
   input  logic [15:0]        pc,
   input  logic [15:0]        break_pc,
   input  logic               break_valid,
   output logic               cpu_clk,
   output logic               cpu_clk_rise,
   output logic               busy,
   output logic [CNT_W-1:0]   cycle_cnt,
   output logic               break_hit
);

   localparam int PH_W = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
   localparam int DB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(DIV_HALF - 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEB_CYCLES - 1);

   localparam logic [1:0] M_RUN   = 2'b00;
   localparam logic [1:0] M_STEP  = 2'b01;
   localparam logic [1:0] M_BURST = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HIGH = 2'd1,
      S_LOW  = 2'd2
   } state_t;

   // ------------------------------------------------------------------
   // Step button: 2-FF synchroniser followed by a stability counter.
   // ------------------------------------------------------------------
   logic            btn_meta;
   logic            btn_sync;
   logic            btn_acc;
   logic            step_evt;
   logic [DB_W-1:0] deb_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         btn_meta <= 1'b0;
         btn_sync <= 1'b0;
         btn_acc  <= 1'b0;
         step_evt <= 1'b0;
         deb_cnt  <= '0;
      end else begin
         btn_meta <= step_btn;
         btn_sync <= btn_meta;
         step_evt <= 1'b0;
         if (btn_sync == btn_acc) begin
            // level agrees with the accepted one: any pending change was a bounce
            deb_cnt <= '0;
         end else if (deb_cnt == DB_LAST) begin
            // DEB_CYCLES consecutive samples of the new level seen
            deb_cnt  <= '0;
            btn_acc  <= btn_sync;
            step_evt <= btn_sync;
         end else begin
            deb_cnt <= deb_cnt + DB_W'(1);
         end
      end
   end

   // ------------------------------------------------------------------
   // Breakpoint qualification
   // ------------------------------------------------------------------
   logic brk_match;   // start/continue would hit the breakpoint
   logic brk_step;    // step event that releases a halted CPU for one cycle
   logic hit_set;

`ifdef CLKCTRL_BREAK_EN
   assign brk_match = break_valid && (pc == break_pc) && ((mode == M_RUN) || (mode == M_BURST));
   assign brk_step  = break_hit && step_evt && (mode != 2'b11);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         break_hit <= 1'b0;
      else if (hit_set)
         break_hit <= 1'b1;
      else if (step_evt)
         break_hit <= 1'b0;
   end
`else
   assign brk_match = 1'b0;
   assign brk_step  = 1'b0;
   assign break_hit = 1'b0;
   logic unused_break;
   assign unused_break = ^{pc, break_pc, break_valid, hit_set};
`endif

   // ------------------------------------------------------------------
   // Clock FSM
   // ------------------------------------------------------------------
   state_t             state, state_nxt;
   logic [PH_W-1:0]    phase, phase_nxt;
   logic [BURST_W-1:0] burst_rem, rem_nxt;
   logic               single, single_nxt;   // current cycle is a breakpoint step-off
   logic               rise_nxt;

   always_comb begin
      state_nxt  = state;
      phase_nxt  = phase;
      rem_nxt    = burst_rem;
      single_nxt = single;
      hit_set    = 1'b0;
      case (state)
         S_IDLE: begin
            phase_nxt = '0;
            if (brk_step) begin
               state_nxt  = S_HIGH;
               single_nxt = 1'b1;
               rem_nxt    = '0;
            end else begin
               case (mode)
                  M_RUN: begin
                     if (brk_match) hit_set = 1'b1;
                     else           state_nxt = S_HIGH;
                  end
                  M_STEP: begin
                     if (step_evt) state_nxt = S_HIGH;
                  end
                  M_BURST: begin
                     if (step_evt && (burst_len != '0)) begin
                        if (brk_match) begin
                           hit_set = 1'b1;
                        end else begin
                           state_nxt = S_HIGH;
                           rem_nxt   = burst_len;
                        end
                     end
                  end
                  default: ;  // hold: never starts
               endcase
            end
         end
         S_HIGH: begin
            if (phase == PH_LAST) begin
               state_nxt = S_LOW;
               phase_nxt = '0;
            end else begin
               phase_nxt = phase + PH_W'(1);
            end
         end
         S_LOW: begin
            if (phase == PH_LAST) begin
               // cycle boundary: default is to stop and clear burst state
               phase_nxt  = '0;
               state_nxt  = S_IDLE;
               rem_nxt    = '0;
               single_nxt = 1'b0;
               if (!single) begin
                  case (mode)
                     M_RUN: begin
                        if (brk_match) hit_set = 1'b1;
                        else           state_nxt = S_HIGH;
                     end
                     M_BURST: begin
                        // burst_rem of 0 or 1 means this was the last cycle (or the
                        // burst was never loaded because mode changed from run)
                        if (burst_rem > BURST_W'(1)) begin
                           if (brk_match) begin
                              hit_set = 1'b1;
                           end else begin
                              state_nxt = S_HIGH;
                              rem_nxt   = burst_rem - BURST_W'(1);
                           end
                        end
                     end
                     default: ;
                  endcase
               end
            end else begin
               phase_nxt = phase + PH_W'(1);
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign rise_nxt = (state_nxt == S_HIGH) && (state != S_HIGH);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= S_IDLE;
         phase        <= '0;
         burst_rem    <= '0;
         single       <= 1'b0;
         cpu_clk      <= 1'b0;
         cpu_clk_rise <= 1'b0;
         busy         <= 1'b0;
         cycle_cnt    <= '0;
      end else begin
         state        <= state_nxt;
         phase        <= phase_nxt;
         burst_rem    <= rem_nxt;
         single       <= single_nxt;
         cpu_clk      <= (state_nxt == S_HIGH);
         cpu_clk_rise <= rise_nxt;
         busy         <= (state_nxt != S_IDLE);
         if (rise_nxt)
            cycle_cnt <= cycle_cnt + CNT_W'(1);
      end
   end

endmodule
